// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad hex entry block.
//   key_state_e : scanner FSM states
//   key_lookup  : (row, col) -> layout key code
//   low_col     : index of the lowest active-low column in a column pattern
package keypad_pkg;

  typedef enum logic [1:0] {
    StScan,
    StDebounce,
    StPress,
    StRelease
  } key_state_e;

  localparam logic [3:0] KeyClr = 4'hE;  // '*'
  localparam logic [3:0] KeyEnt = 4'hF;  // '#'

  // Layout: r0: 1 2 3 A | r1: 4 5 6 B | r2: 7 8 9 C | r3: * 0 # D
  function automatic logic [3:0] key_lookup(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    unique case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KeyClr;
      4'hD: code = 4'h0;
      4'hE: code = KeyEnt;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // Lowest-index low column wins when several keys in a row are held.
  function automatic logic [1:0] low_col(input logic [3:0] col);
    logic [1:0] idx;
    if (!col[0]) begin
      idx = 2'd0;
    end else if (!col[1]) begin
      idx = 2'd1;
    end else if (!col[2]) begin
      idx = 2'd2;
    end else begin
      idx = 2'd3;
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Stability counter shared by the press and release debounce phases.
//   match_i   : input currently equals the pattern being qualified
//   restart_i : force the count back to zero
//   done_o    : asserted on the DEBOUNCE_CYC-th consecutive matching cycle
module keypad_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic match_i,
  input  logic restart_i,
  output logic done_o
);

  localparam int unsigned CntW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(DEBOUNCE_CYC - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    done_o = match_i && !restart_i && (cnt_q == CntLast);
    if (restart_i || !match_i || done_o) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/keypad_hex_entry.sv
// 4x4 matrix keypad scanner with debounce and 16-bit hex entry word.
//   clk, rst_n   : clock, asynchronous active-low reset
//   col_in       : keypad columns (active low, asynchronous)
//   row_out      : one-hot-low row drive
//   entry_value  : word being typed (live display value)
//   key_strobe   : one-cycle pulse per accepted key; key_code holds its layout code
//   data_out/data_valid/data_ready : committed word handshake toward the CPU
//   overflow     : one-cycle pulse when '#' is dropped because a word is still pending
module keypad_hex_entry
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV     = 50000,
  parameter int unsigned DEBOUNCE_CYC = 1000000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  col_in,
  output logic [3:0]  row_out,
  output logic [15:0] entry_value,
  output logic        key_strobe,
  output logic [3:0]  key_code,
  output logic [15:0] data_out,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        overflow
);

  localparam int unsigned SlotW = $clog2(SCAN_DIV);
  localparam logic [SlotW-1:0] SlotLast = SlotW'(SCAN_DIV - 1);

  key_state_e       state_q, state_d;
  logic [3:0]       col_meta_q, col_s_q;
  logic [1:0]       row_q, row_d;
  logic [SlotW-1:0] slot_q, slot_d;
  logic [3:0]       pat_q, pat_d;
  logic [3:0]       code_q, code_d;
  logic [15:0]      entry_q, entry_d;
  logic [15:0]      data_q, data_d;
  logic             valid_q, valid_d;
  logic [3:0]       key_code_q, key_code_d;
  logic             strobe_q, strobe_d;
  logic             ovf_q, ovf_d;
  logic             db_match, db_restart, db_done;

  // Release waits for all columns high; press waits for the latched pattern to persist.
  assign db_match   = (state_q == StRelease) ? (col_s_q == 4'hF) : (col_s_q == pat_q);
  assign db_restart = !((state_q == StDebounce) || (state_q == StRelease));

  keypad_debounce #(
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .match_i  (db_match),
    .restart_i(db_restart),
    .done_o   (db_done)
  );

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    slot_d     = slot_q;
    pat_d      = pat_q;
    code_d     = code_q;
    entry_d    = entry_q;
    data_d     = data_q;
    valid_d    = valid_q;
    key_code_d = key_code_q;
    strobe_d   = 1'b0;
    ovf_d      = 1'b0;

    if (valid_q && data_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      StScan: begin
        if (slot_q == SlotLast) begin
          slot_d = '0;
          if (col_s_q != 4'hF) begin
            // Row drive stays frozen while the key is qualified.
            pat_d   = col_s_q;
            code_d  = key_lookup(row_q, low_col(col_s_q));
            state_d = StDebounce;
          end else begin
            row_d = row_q + 2'd1;
          end
        end else begin
          slot_d = slot_q + 1'b1;
        end
      end
      StDebounce: begin
        if (!db_match) begin
          row_d   = row_q + 2'd1;
          state_d = StScan;
        end else if (db_done) begin
          state_d = StPress;
        end
      end
      StPress: begin
        strobe_d   = 1'b1;
        key_code_d = code_q;
        state_d    = StRelease;
        if (code_q == KeyClr) begin
          entry_d = '0;
        end else if (code_q == KeyEnt) begin
          // A word accepted this very cycle frees the slot for the new commit.
          if (!valid_q || data_ready) begin
            data_d  = entry_q;
            valid_d = 1'b1;
            entry_d = '0;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          entry_d = {entry_q[11:0], code_q};
        end
      end
      StRelease: begin
        if (db_done) begin
          row_d   = row_q + 2'd1;
          state_d = StScan;
        end
      end
      default: state_d = StScan;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StScan;
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
      row_q      <= '0;
      slot_q     <= '0;
      pat_q      <= 4'hF;
      code_q     <= '0;
      entry_q    <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      key_code_q <= '0;
      strobe_q   <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_meta_q <= col_in;
      col_s_q    <= col_meta_q;
      row_q      <= row_d;
      slot_q     <= slot_d;
      pat_q      <= pat_d;
      code_q     <= code_d;
      entry_q    <= entry_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      key_code_q <= key_code_d;
      strobe_q   <= strobe_d;
      ovf_q      <= ovf_d;
    end
  end

  assign row_out     = ~(4'b0001 << row_q);
  assign entry_value = entry_q;
  assign key_strobe  = strobe_q;
  assign key_code    = key_code_q;
  assign data_out    = data_q;
  assign data_valid  = valid_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_keypad_hex_entry.sv
// Directed bench for keypad_hex_entry with a behavioural 4x4 keypad model.
module tb_keypad_hex_entry;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  col_in;
  logic [3:0]  row_out;
  logic [15:0] entry_value;
  logic        key_strobe;
  logic [3:0]  key_code;
  logic [15:0] data_out;
  logic        data_valid;
  logic        data_ready;
  logic        overflow;

  logic [15:0] held;         // bit r*4+c: key at (row r, col c) is held
  logic        bounce_open;  // forces the contacts open regardless of held
  int          strobe_cnt;
  int          ovf_cnt;
  int          n_checks;
  int          n_fail;

  always #5 clk = ~clk;

  keypad_hex_entry #(
    .SCAN_DIV    (4),
    .DEBOUNCE_CYC(8)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .col_in     (col_in),
    .row_out    (row_out),
    .entry_value(entry_value),
    .key_strobe (key_strobe),
    .key_code   (key_code),
    .data_out   (data_out),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .overflow   (overflow)
  );

  // A held key pulls its column low while its row is driven low.
  always_comb begin
    col_in = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (held[r*4+c] && !row_out[r] && !bounce_open) col_in[c] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (key_strobe) strobe_cnt <= strobe_cnt + 1;
    if (overflow) ovf_cnt <= ovf_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int kidx(input int r, input int c);
    return r * 4 + c;
  endfunction

  task automatic wait_strobe(input int start, input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (strobe_cnt != start) seen = 1'b1;
    end
    check({tag, " strobe seen"}, 32'(seen), 32'd1);
  endtask

  // Press the keys in mask, wait for the strobe, release and confirm a single strobe.
  task automatic press(input logic [15:0] mask, input string tag);
    int start;
    start = strobe_cnt;
    held  = mask;
    wait_strobe(start, tag);
    repeat (5) @(negedge clk);
    held = '0;
    repeat (30) @(negedge clk);
    check({tag, " one strobe"}, 32'(strobe_cnt - start), 32'd1);
  endtask

  initial begin
    logic [3:0]  exp_row;
    logic [15:0] m;
    int          start;
    int          run;
    n_checks    = 0;
    n_fail      = 0;
    strobe_cnt  = 0;
    ovf_cnt     = 0;
    held        = '0;
    bounce_open = 1'b0;
    data_ready  = 1'b0;
    rst_n       = 1'b0;

    // 1. Reset values and row rotation
    repeat (3) @(negedge clk);
    check("rst row_out", 32'(row_out), 32'hE);
    check("rst entry", 32'(entry_value), 32'h0);
    check("rst key_code", 32'(key_code), 32'h0);
    check("rst data_out", 32'(data_out), 32'h0);
    check("rst data_valid", 32'(data_valid), 32'h0);
    check("rst key_strobe", 32'(key_strobe), 32'h0);
    check("rst overflow", 32'(overflow), 32'h0);
    rst_n = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      exp_row = ~(4'b0001 << ((k / 4) % 4));
      check("row rotate", 32'(row_out), 32'(exp_row));
      @(negedge clk);
    end

    // 2. Clean hex entry
    m = '0; m[kidx(0, 0)] = 1'b1; press(m, "key 1");
    check("entry after 1", 32'(entry_value), 32'h0001);
    check("code 1", 32'(key_code), 32'h1);
    m = '0; m[kidx(0, 1)] = 1'b1; press(m, "key 2");
    check("entry after 2", 32'(entry_value), 32'h0012);
    check("code 2", 32'(key_code), 32'h2);
    m = '0; m[kidx(0, 3)] = 1'b1; press(m, "key A");
    check("entry after A", 32'(entry_value), 32'h012A);
    check("code A", 32'(key_code), 32'hA);
    m = '0; m[kidx(1, 1)] = 1'b1; press(m, "key 5");
    check("entry after 5", 32'(entry_value), 32'h12A5);
    check("code 5", 32'(key_code), 32'h5);

    // 3. Commit, overflow, handshake
    m = '0; m[kidx(3, 2)] = 1'b1; press(m, "enter 1");
    check("commit data_out", 32'(data_out), 32'h12A5);
    check("commit valid", 32'(data_valid), 32'h1);
    check("commit entry clr", 32'(entry_value), 32'h0);
    check("code ent", 32'(key_code), 32'hF);
    m = '0; m[kidx(0, 2)] = 1'b1; press(m, "key 3");
    check("entry after 3", 32'(entry_value), 32'h0003);
    start = ovf_cnt;
    m = '0; m[kidx(3, 2)] = 1'b1; press(m, "enter 2");
    check("overflow pulses", 32'(ovf_cnt - start), 32'd1);
    check("ovf data_out kept", 32'(data_out), 32'h12A5);
    check("ovf entry kept", 32'(entry_value), 32'h0003);
    check("ovf valid kept", 32'(data_valid), 32'h1);
    data_ready = 1'b1;
    check("valid before accept", 32'(data_valid), 32'h1);
    @(negedge clk);
    check("valid after accept", 32'(data_valid), 32'h0);
    data_ready = 1'b0;

    // 4. Bouncing press and release of '6'
    start = strobe_cnt;
    held  = '0;
    held[kidx(1, 2)] = 1'b1;
    bounce_open = 1'b1;
    for (int i = 0; i < 12; i++) begin
      repeat (3) @(negedge clk);
      bounce_open = ~bounce_open;
    end
    bounce_open = 1'b0;
    check("bounce no strobe", 32'(strobe_cnt - start), 32'd0);
    wait_strobe(start, "bounce");
    check("bounce code 6", 32'(key_code), 32'h6);
    check("entry after 6", 32'(entry_value), 32'h0036);
    for (int i = 0; i < 12; i++) begin
      repeat (3) @(negedge clk);
      bounce_open = ~bounce_open;
    end
    held = '0;
    bounce_open = 1'b0;
    repeat (30) @(negedge clk);
    check("bounce one strobe", 32'(strobe_cnt - start), 32'd1);

    // 5. Two keys in one row, then clear
    m = '0; m[kidx(2, 0)] = 1'b1; m[kidx(2, 2)] = 1'b1; press(m, "keys 7+9");
    check("code 7 wins", 32'(key_code), 32'h7);
    check("entry after 7", 32'(entry_value), 32'h0367);
    m = '0; m[kidx(3, 0)] = 1'b1; press(m, "key *");
    check("entry cleared", 32'(entry_value), 32'h0);
    check("code clr", 32'(key_code), 32'hE);

    // 6. Reset during debounce of '8'
    held = '0;
    held[kidx(2, 1)] = 1'b1;
    run = 0;
    for (int i = 0; i < 100 && run < 6; i++) begin
      @(negedge clk);
      run = (row_out == 4'b1011) ? run + 1 : 0;
    end
    check("row2 frozen", 32'(run), 32'd6);
    start = strobe_cnt;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("mid rst row_out", 32'(row_out), 32'hE);
    rst_n = 1'b1;
    repeat (18) @(negedge clk);
    check("no early strobe", 32'(strobe_cnt - start), 32'd0);
    wait_strobe(start, "post rst");
    check("post rst code 8", 32'(key_code), 32'h8);
    check("post rst entry", 32'(entry_value), 32'h0008);
    held = '0;
    repeat (30) @(negedge clk);
    check("post rst one strobe", 32'(strobe_cnt - start), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
